exibidor_sequencia: RTL



---
 rtl/exibidor_sequencia_pkg.sv | 28 ++
 rtl/exibidor_sequencia_if.sv | 28 ++
 rtl/exibidor_sequencia_temporizador_fase.sv | 34 +++
 rtl/exibidor_sequencia.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/exibidor_sequencia_pkg.sv
// Shared encodings and defaults for the sequence player (exibidor_sequencia).
package exibidor_pkg;

   localparam int unsigned ADDR_W_DEF    = 4;
   localparam int unsigned DATA_W_DEF    = 4;
   localparam int unsigned T_ACESO_DEF   = 500;
   localparam int unsigned T_APAGADO_DEF = 250;
   localparam int unsigned T_PAUSA_DEF   = 500;
   localparam int unsigned ESTADO_W      = 3;

   typedef enum logic [ESTADO_W-1:0] {
      OCIOSO    = 3'd0,
      CARREGA   = 3'd1,
      ACENDE    = 3'd2,
      APAGA     = 3'd3,
      CONCLUIDO = 3'd4,
      PAUSA     = 3'd5
   } estado_e;

   // Largest of three phase lengths; sizes the shared phase timer.
   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/exibidor_sequencia_if.sv
// Player <-> control/RAM signal bundle; master is the control side, slave is the player.
interface exibidor_sequencia_if
   import exibidor_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) ();

   logic                iniciar;
   logic [ADDR_W-1:0]   limite;
   logic [DATA_W-1:0]   dado_memoria;
   logic [ADDR_W-1:0]   endereco;
   logic [DATA_W-1:0]   leds;
   logic                ocupado;
   logic                fim;
   logic [ESTADO_W-1:0] db_estado;

   modport master (
      output iniciar, limite, dado_memoria,
      input  endereco, leds, ocupado, fim, db_estado
   );

   modport slave (
      input  iniciar, limite, dado_memoria,
      output endereco, leds, ocupado, fim, db_estado
   );

endinterface

// File: rtl/exibidor_sequencia_temporizador_fase.sv
// Modulo phase counter: counts 0..alvo_i while conta_i, flags the terminal count.
module temporizador_fase #(
   parameter int unsigned W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera_i,
   input  logic         conta_i,
   input  logic [W-1:0] alvo_i,
   output logic         fim_tempo_c
);

   logic [W-1:0] cnt_q, cnt_d;

   assign fim_tempo_c = (cnt_q == alvo_i);

   always_comb begin
      cnt_d = cnt_q;
      if (zera_i) begin
         cnt_d = '0;
      end else if (conta_i) begin
         cnt_d = fim_tempo_c ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/exibidor_sequencia.sv
// Sequence player: shows RAM entries 0..limite on the LEDs with timed on/off phases.
// Optional initial blank phase enabled by defining EXIBIDOR_PAUSA_INICIAL_EN.
module exibidor_sequencia
   import exibidor_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned T_ACESO   = T_ACESO_DEF,
   parameter int unsigned T_APAGADO = T_APAGADO_DEF,
   parameter int unsigned T_PAUSA   = T_PAUSA_DEF
) (
   input  logic                 clock,
   input  logic                 reset,
   exibidor_sequencia_if.slave  bus
);

   localparam int unsigned TW = $clog2(max3(T_ACESO, T_APAGADO, T_PAUSA) + 1);

   estado_e           estado_q, estado_d;
   logic [ADDR_W-1:0] endereco_q, endereco_d;
   logic [ADDR_W-1:0] limite_q, limite_d;
   logic [DATA_W-1:0] leds_q, leds_d;
   logic              fim_q, fim_d;
   logic              ocupado_q, ocupado_d;

   logic              zera, conta, fim_tempo;
   logic [TW-1:0]     alvo;

   temporizador_fase #(.W(TW)) u_temporizador (
      .clock       (clock),
      .reset       (reset),
      .zera_i      (zera),
      .conta_i     (conta),
      .alvo_i      (alvo),
      .fim_tempo_c (fim_tempo)
   );

   // Next-state and output decode; timer is cleared on every phase exit.
   always_comb begin
      estado_d   = estado_q;
      endereco_d = endereco_q;
      limite_d   = limite_q;
      leds_d     = leds_q;
      fim_d      = 1'b0;
      zera       = 1'b0;
      conta      = 1'b0;
      alvo       = '0;

      case (estado_q)
         OCIOSO: begin
            zera = 1'b1;
            if (bus.iniciar) begin
               limite_d   = bus.limite;
               endereco_d = '0;
               leds_d     = '0;
`ifdef EXIBIDOR_PAUSA_INICIAL_EN
               estado_d   = PAUSA;
`else
               estado_d   = CARREGA;
`endif
            end
         end
         CARREGA: begin
            zera     = 1'b1;
            leds_d   = bus.dado_memoria;
            estado_d = ACENDE;
         end
         ACENDE: begin
            alvo  = TW'(T_ACESO - 1);
            conta = 1'b1;
            if (fim_tempo) begin
               zera     = 1'b1;
               leds_d   = '0;
               estado_d = APAGA;
            end
         end
         APAGA: begin
            alvo  = TW'(T_APAGADO - 1);
            conta = 1'b1;
            if (fim_tempo) begin
               zera = 1'b1;
               // Compare before increment so the address never wraps.
               if (endereco_q == limite_q) begin
                  fim_d    = 1'b1;
                  estado_d = CONCLUIDO;
               end else begin
                  endereco_d = endereco_q + ADDR_W'(1);
                  estado_d   = CARREGA;
               end
            end
         end
         CONCLUIDO: begin
            zera     = 1'b1;
            estado_d = OCIOSO;
         end
`ifdef EXIBIDOR_PAUSA_INICIAL_EN
         PAUSA: begin
            alvo  = TW'(T_PAUSA - 1);
            conta = 1'b1;
            if (fim_tempo) begin
               zera     = 1'b1;
               estado_d = CARREGA;
            end
         end
`endif
         default: begin
            zera     = 1'b1;
            leds_d   = '0;
            estado_d = OCIOSO;
         end
      endcase

      ocupado_d = (estado_d != OCIOSO);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q   <= OCIOSO;
         endereco_q <= '0;
         limite_q   <= '0;
         leds_q     <= '0;
         fim_q      <= 1'b0;
         ocupado_q  <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         endereco_q <= endereco_d;
         limite_q   <= limite_d;
         leds_q     <= leds_d;
         fim_q      <= fim_d;
         ocupado_q  <= ocupado_d;
      end
   end

   assign bus.endereco  = endereco_q;
   assign bus.leds      = leds_q;
   assign bus.fim       = fim_q;
   assign bus.ocupado   = ocupado_q;
   assign bus.db_estado = estado_q;

endmodule
